program_flow_unit: RTL and testbench
====================================

# program_flow_unit

Sequential program-flow stage downstream of the program decoder. It owns the program counter, a hardware stack for return addresses and data, the mini-ALU that forms branch targets, and the context register. On each retire strobe it consumes one cycle's decoder flags and operands, updates PC/stack/context, and issues a one-cycle register writeback for POP and GSA.

## Interface
Parameters:
- DEPTH, 16: stack entries, 32 bits each; power of two, from 2 to 256.
- RESET_PC, 16'h0000: PC value after reset.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset  in  1  synchronous, active-high reset.
- step  in  1  retire strobe; state advances only on cycles where step=1.
- JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, GSA_flag, SWITCH_flag  in  1 each  decoder action flags.
- Mini_ALU_op  in  4  0 = add, 1 = subtract; any other value is treated as add.
- Mini_ALU_v1, Mini_ALU_v2  in  32 each  mini-ALU operands.
- PC_pos  out  16  current program counter.
- sp  out  $clog2(DEPTH)+1  stack occupancy, from 0 to DEPTH.
- stack_empty, stack_full  out  1 each  sp==0 and sp==DEPTH respectively.
- ctx  out  8  context register, written by SWITCH.
- wb_valid  out  1  one-cycle register-write request.
- wb_addr  out  8  destination register code.
- wb_data  out  32  value to write.
- fault  out  1  sticky stack overflow/underflow indicator.

## Operation
- target = (op==1 ? v1 - v2 : v1 + v2), modulo 2^32; PC uses target[15:0].
- pc_next = PC_pos + 1, modulo 2^16; 16'hFFFF wraps to 0.
- On step=1 with fault=0, exactly one action is taken. Priority is CALL > RET > JMP > PUSH > POP > GSA > SWITCH; lower flags set in the same cycle are ignored.
  - CALL: push {16'b0, pc_next}; PC <= target.
  - RET: pop; PC <= popped[15:0].
  - JMP: PC <= target. HALT arrives as JMP to PC_pos, so PC stays put.
  - PUSH: push v1; PC <= pc_next.
  - POP: pop; wb_valid=1, wb_addr=v1[7:0], wb_data=popped; PC <= pc_next.
  - GSA: wb_valid=1, wb_addr=v1[7:0], wb_data=sp zero-extended to 32 bits; PC <= pc_next.
  - SWITCH: ctx <= v1[7:0]; PC <= pc_next.
  - No flag set: PC <= pc_next.
- Stack is LIFO: push writes mem[sp] and sets sp+1; pop reads mem[sp-1] and sets sp-1.
- Overflow (CALL or PUSH when full) and underflow (RET or POP when empty):
  - fault <= 1.
  - PC, stack and ctx are left unchanged; no writeback is issued.
- While fault=1, every step is ignored: PC, sp, ctx and mem are frozen and wb_valid=0. Only reset clears fault.
- With step=0, all state holds and wb_valid=0.
- Reset values: PC_pos=RESET_PC, sp=0, ctx=0, fault=0, wb_valid=0, wb_addr=0, wb_data=0. Stack contents are not cleared (don't-care).

## Timing
- All outputs are registered.
- An action sampled on edge N is visible after edge N:
  - PC_pos, sp, ctx and fault change on edge N.
  - wb_* are valid for exactly the cycle after edge N, then wb_valid returns to 0 unless the next step issues another writeback.
- One action per cycle. Back-to-back steps are supported with no bubbles, e.g. PUSH then POP on consecutive cycles returns the pushed value.
- GSA reports sp as it was before edge N.
- Stack top is read combinationally from the array. A push on edge N is poppable on edge N+1.
- reset has priority over step. Reset mid-sequence discards the in-flight action. The cycle after reset: PC_pos=RESET_PC, wb_valid=0.
- The fault transition and the frozen state appear on the same edge as the offending step.

## Test plan
- Reset, then 3 steps with no flags -> PC_pos reads 0, 1, 2, 3. Hold step=0 for 2 cycles -> PC_pos stays 3.
- At PC=5: CALL with v1=0x40, v2=0 -> PC=0x40, sp=1. Then RET -> PC=6, sp=0, stack_empty=1.
- PC=0x20, JMP with op=1, v1=0x20, v2=0x8 -> PC=0x18. Then op=0, v1=0xFFFF, v2=2 -> PC=0x0001 (wraps).
- Sequence:
  - PUSH v1=0xDEADBEEF -> sp=1.
  - GSA v1=3 -> next cycle wb_valid=1, wb_addr=3, wb_data=1.
  - POP v1=7 -> next cycle wb_valid=1, wb_addr=7, wb_data=0xDEADBEEF, sp=0.
- DEPTH=16:
  - 16 PUSHes -> stack_full=1.
  - 17th PUSH -> fault=1, sp=16, PC unchanged. Further JMPs are ignored.
  - reset -> fault=0, PC=RESET_PC.
- Same cycle CALL+PUSH+SWITCH with v1=0x10 -> only CALL: PC=0x10, sp=1, ctx unchanged. Separately, POP on empty -> fault=1, wb_valid stays 0.

Source files
------------

// File: rtl/program_flow_unit.sv
// Program-flow stage: program counter, LIFO return/data stack, branch-target
// mini-ALU, context register and a one-cycle writeback port for POP and GSA.
module program_flow_unit #(
    parameter int          DEPTH    = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       JMP_flag,
    input  logic                       CALL_flag,
    input  logic                       RET_flag,
    input  logic                       PUSH_flag,
    input  logic                       POP_flag,
    input  logic                       GSA_flag,
    input  logic                       SWITCH_flag,
    input  logic [3:0]                 Mini_ALU_op,
    input  logic [31:0]                Mini_ALU_v1,
    input  logic [31:0]                Mini_ALU_v2,
    output logic [15:0]                PC_pos,
    output logic [$clog2(DEPTH):0]     sp,
    output logic                       stack_empty,
    output logic                       stack_full,
    output logic [7:0]                 ctx,
    output logic                       wb_valid,
    output logic [7:0]                 wb_addr,
    output logic [31:0]                wb_data,
    output logic                       fault
);

    localparam int AW  = $clog2(DEPTH);
    localparam int SPW = AW + 1;

    // step is a retire strobe with no back-pressure; wb_valid is a one-cycle
    // pulse with no ready, the register file must accept it when it fires.

    logic [31:0]    mem_q [DEPTH];
    logic [15:0]    pc_q, pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic [7:0]     ctx_q, ctx_d;
    logic           fault_q, fault_d;
    logic           empty_q, full_q;
    logic           wb_valid_q, wb_valid_d;
    logic [7:0]     wb_addr_q, wb_addr_d;
    logic [31:0]    wb_data_q, wb_data_d;

    logic           push_en;
    logic [31:0]    push_data;
    logic [AW-1:0]  push_idx, top_idx;
    logic [31:0]    top;
    logic [31:0]    target;
    logic [15:0]    pc_next;
    logic           is_empty, is_full;
    logic           unused_target_hi;

    assign target           = (Mini_ALU_op == 4'd1) ? (Mini_ALU_v1 - Mini_ALU_v2)
                                                    : (Mini_ALU_v1 + Mini_ALU_v2);
    assign unused_target_hi = ^target[31:16];
    assign pc_next          = pc_q + 16'd1;
    assign is_empty         = (sp_q == '0);
    assign is_full          = (sp_q == SPW'(DEPTH));
    assign push_idx         = sp_q[AW-1:0];
    assign top_idx          = sp_q[AW-1:0] - AW'(1);
    assign top              = mem_q[top_idx];

    always_comb begin
        pc_d       = pc_q;
        sp_d       = sp_q;
        ctx_d      = ctx_q;
        fault_d    = fault_q;
        wb_valid_d = 1'b0;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
        push_en    = 1'b0;
        push_data  = '0;
        if (step && !fault_q) begin
            // Overflow/underflow only raises fault; everything else stays put.
            if (CALL_flag) begin
                if (is_full) begin
                    fault_d = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    push_data = {16'b0, pc_next};
                    sp_d      = sp_q + SPW'(1);
                    pc_d      = target[15:0];
                end
            end else if (RET_flag) begin
                if (is_empty) begin
                    fault_d = 1'b1;
                end else begin
                    sp_d = sp_q - SPW'(1);
                    pc_d = top[15:0];
                end
            end else if (JMP_flag) begin
                pc_d = target[15:0];
            end else if (PUSH_flag) begin
                if (is_full) begin
                    fault_d = 1'b1;
                end else begin
                    push_en   = 1'b1;
                    push_data = Mini_ALU_v1;
                    sp_d      = sp_q + SPW'(1);
                    pc_d      = pc_next;
                end
            end else if (POP_flag) begin
                if (is_empty) begin
                    fault_d = 1'b1;
                end else begin
                    sp_d       = sp_q - SPW'(1);
                    wb_valid_d = 1'b1;
                    wb_addr_d  = Mini_ALU_v1[7:0];
                    wb_data_d  = top;
                    pc_d       = pc_next;
                end
            end else if (GSA_flag) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = Mini_ALU_v1[7:0];
                wb_data_d  = 32'(sp_q);
                pc_d       = pc_next;
            end else if (SWITCH_flag) begin
                ctx_d = Mini_ALU_v1[7:0];
                pc_d  = pc_next;
            end else begin
                pc_d = pc_next;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            sp_q       <= '0;
            ctx_q      <= '0;
            fault_q    <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            sp_q       <= sp_d;
            ctx_q      <= ctx_d;
            fault_q    <= fault_d;
            empty_q    <= (sp_d == '0);
            full_q     <= (sp_d == SPW'(DEPTH));
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // Stack storage has no reset; sp alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (!reset && push_en) begin
            mem_q[push_idx] <= push_data;
        end
    end

    assign PC_pos      = pc_q;
    assign sp          = sp_q;
    assign stack_empty = empty_q;
    assign stack_full  = full_q;
    assign ctx         = ctx_q;
    assign wb_valid    = wb_valid_q;
    assign wb_addr     = wb_addr_q;
    assign wb_data     = wb_data_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_program_flow_unit.sv
// Bench for program_flow_unit: directed scenarios plus random steps checked
// against a queue-based reference model of PC, stack, context and writeback.
module tb_program_flow_unit;

    localparam int          DEPTH    = 16;
    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          SPW      = $clog2(DEPTH) + 1;

    // flag vector bit order: {CALL, RET, JMP, PUSH, POP, GSA, SWITCH}
    localparam logic [6:0] F_NONE = 7'b0000000;
    localparam logic [6:0] F_CALL = 7'b1000000;
    localparam logic [6:0] F_RET  = 7'b0100000;
    localparam logic [6:0] F_JMP  = 7'b0010000;
    localparam logic [6:0] F_PUSH = 7'b0001000;
    localparam logic [6:0] F_POP  = 7'b0000100;
    localparam logic [6:0] F_GSA  = 7'b0000010;
    localparam logic [6:0] F_SW   = 7'b0000001;

    logic clock = 1'b0;
    logic reset, step;
    logic JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag, GSA_flag, SWITCH_flag;
    logic [3:0]     Mini_ALU_op;
    logic [31:0]    Mini_ALU_v1, Mini_ALU_v2;
    logic [15:0]    PC_pos;
    logic [SPW-1:0] sp;
    logic           stack_empty, stack_full;
    logic [7:0]     ctx;
    logic           wb_valid;
    logic [7:0]     wb_addr;
    logic [31:0]    wb_data;
    logic           fault;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [31:0] m_stk[$];
    logic [7:0]  m_ctx;
    logic        m_fault;
    logic        m_wbv;
    logic [7:0]  m_wba;
    logic [31:0] m_wbd;

    program_flow_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .step(step),
        .JMP_flag(JMP_flag), .CALL_flag(CALL_flag), .RET_flag(RET_flag),
        .PUSH_flag(PUSH_flag), .POP_flag(POP_flag), .GSA_flag(GSA_flag),
        .SWITCH_flag(SWITCH_flag), .Mini_ALU_op(Mini_ALU_op),
        .Mini_ALU_v1(Mini_ALU_v1), .Mini_ALU_v2(Mini_ALU_v2),
        .PC_pos(PC_pos), .sp(sp), .stack_empty(stack_empty), .stack_full(stack_full),
        .ctx(ctx), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .fault(fault)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic rst, input logic stp, input logic [6:0] fl,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] tgt;
        logic [31:0] v;
        logic [15:0] nxt;
        if (rst) begin
            m_pc = RESET_PC; m_stk.delete(); m_ctx = 0; m_fault = 0;
            m_wbv = 0; m_wba = 0; m_wbd = 0;
            return;
        end
        m_wbv = 0;
        if (!stp || m_fault) return;
        tgt = (op == 4'd1) ? a - b : a + b;
        nxt = m_pc + 16'd1;
        if (fl[6]) begin
            if (m_stk.size() == DEPTH) m_fault = 1;
            else begin m_stk.push_back({16'h0, nxt}); m_pc = tgt[15:0]; end
        end else if (fl[5]) begin
            if (m_stk.size() == 0) m_fault = 1;
            else begin v = m_stk.pop_back(); m_pc = v[15:0]; end
        end else if (fl[4]) begin
            m_pc = tgt[15:0];
        end else if (fl[3]) begin
            if (m_stk.size() == DEPTH) m_fault = 1;
            else begin m_stk.push_back(a); m_pc = nxt; end
        end else if (fl[2]) begin
            if (m_stk.size() == 0) m_fault = 1;
            else begin
                m_wbv = 1; m_wba = a[7:0]; m_wbd = m_stk.pop_back(); m_pc = nxt;
            end
        end else if (fl[1]) begin
            m_wbv = 1; m_wba = a[7:0]; m_wbd = m_stk.size(); m_pc = nxt;
        end else if (fl[0]) begin
            m_ctx = a[7:0]; m_pc = nxt;
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic compare_all();
        check("pc", 32'(PC_pos), 32'(m_pc));
        check("sp", 32'(sp), m_stk.size());
        check("empty", 32'(stack_empty), 32'(m_stk.size() == 0));
        check("full", 32'(stack_full), 32'(m_stk.size() == DEPTH));
        check("ctx", 32'(ctx), 32'(m_ctx));
        check("fault", 32'(fault), 32'(m_fault));
        check("wb_valid", 32'(wb_valid), 32'(m_wbv));
        if (m_wbv) begin
            check("wb_addr", 32'(wb_addr), 32'(m_wba));
            check("wb_data", wb_data, m_wbd);
        end
    endtask

    task automatic cyc(input logic rst, input logic stp, input logic [6:0] fl,
                       input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        reset = rst; step = stp;
        {CALL_flag, RET_flag, JMP_flag, PUSH_flag, POP_flag, GSA_flag, SWITCH_flag} = fl;
        Mini_ALU_op = op; Mini_ALU_v1 = a; Mini_ALU_v2 = b;
        @(posedge clock);
        #1;
        model(rst, stp, fl, op, a, b);
        compare_all();
    endtask

    task automatic go(input logic [6:0] fl, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b);
        cyc(1'b0, 1'b1, fl, op, a, b);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, F_NONE, 4'd0, 32'd0, 32'd0);
        cyc(1'b1, 1'b0, F_NONE, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        do_reset();
        check("rst_pc", 32'(PC_pos), 32'(RESET_PC));
        check("rst_wbd", wb_data, 32'd0);
        check("rst_wba", 32'(wb_addr), 32'd0);

        for (int i = 1; i <= 3; i++) begin
            go(F_NONE, 4'd0, 32'd0, 32'd0);
            check("seq_pc", 32'(PC_pos), i);
        end
        cyc(1'b0, 1'b0, F_JMP, 4'd0, 32'h55, 32'd0);
        cyc(1'b0, 1'b0, F_NONE, 4'd0, 32'd0, 32'd0);
        check("hold_pc", 32'(PC_pos), 32'd3);

        go(F_JMP, 4'd0, 32'd5, 32'd0);
        go(F_CALL, 4'd0, 32'h40, 32'd0);
        check("call_pc", 32'(PC_pos), 32'h40);
        check("call_sp", 32'(sp), 32'd1);
        go(F_RET, 4'd0, 32'd0, 32'd0);
        check("ret_pc", 32'(PC_pos), 32'd6);
        check("ret_empty", 32'(stack_empty), 32'd1);

        go(F_JMP, 4'd0, 32'h20, 32'd0);
        go(F_JMP, 4'd1, 32'h20, 32'h8);
        check("jmp_sub", 32'(PC_pos), 32'h18);
        go(F_JMP, 4'd0, 32'hFFFF, 32'd2);
        check("jmp_wrap", 32'(PC_pos), 32'h1);
        go(F_JMP, 4'd7, 32'h100, 32'h3);
        check("jmp_opx", 32'(PC_pos), 32'h103);

        go(F_PUSH, 4'd0, 32'hDEADBEEF, 32'd0);
        go(F_GSA, 4'd0, 32'd3, 32'd0);
        check("gsa_data", wb_data, 32'd1);
        check("gsa_addr", 32'(wb_addr), 32'd3);
        go(F_POP, 4'd0, 32'd7, 32'd0);
        check("pop_data", wb_data, 32'hDEADBEEF);
        check("pop_valid", 32'(wb_valid), 32'd1);
        go(F_NONE, 4'd0, 32'd0, 32'd0);
        check("wb_drop", 32'(wb_valid), 32'd0);

        for (int i = 0; i < DEPTH; i++) go(F_PUSH, 4'd0, 32'h1000 + i, 32'd0);
        check("full", 32'(stack_full), 32'd1);
        go(F_PUSH, 4'd0, 32'hBAD, 32'd0);
        check("ovf_fault", 32'(fault), 32'd1);
        check("ovf_sp", 32'(sp), DEPTH);
        go(F_JMP, 4'd0, 32'h77, 32'd0);
        go(F_SW, 4'd0, 32'h77, 32'd0);
        check("frozen_ctx", 32'(ctx), 32'd0);
        do_reset();
        check("clr_fault", 32'(fault), 32'd0);

        go(F_SW, 4'd0, 32'h5A, 32'd0);
        go(F_CALL | F_PUSH | F_SW, 4'd0, 32'h10, 32'd0);
        check("prio_pc", 32'(PC_pos), 32'h10);
        check("prio_ctx", 32'(ctx), 32'h5A);
        cyc(1'b1, 1'b1, F_PUSH, 4'd0, 32'h1, 32'd0);
        check("rst_mid_sp", 32'(sp), 32'd0);
        go(F_POP, 4'd0, 32'd9, 32'd0);
        check("udf_fault", 32'(fault), 32'd1);
        check("udf_wbv", 32'(wb_valid), 32'd0);
        do_reset();

        for (int n = 0; n < 1500; n++) begin
            logic rst, stp;
            logic [6:0] fl;
            logic [3:0] op;
            int pick;
            rst  = ($urandom_range(0, 99) < 2) || (m_fault && $urandom_range(0, 5) == 0);
            stp  = ($urandom_range(0, 9) != 0);
            pick = $urandom_range(0, 11);
            case (pick)
                0:       fl = F_CALL;
                1:       fl = F_RET;
                2:       fl = F_JMP;
                3, 4, 5: fl = F_PUSH;
                6, 7:    fl = F_POP;
                8:       fl = F_GSA;
                9:       fl = F_SW;
                default: fl = F_NONE;
            endcase
            if ($urandom_range(0, 3) == 0) fl = fl | 7'($urandom);
            op = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
            cyc(rst, stp, fl, op, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
